// File: rtl/dmem_arbiter_if.sv
// Shared data-memory port bundle: two core-side request/response channels,
// the single downstream dmem port, and the owner debug tap.
interface dmem_arbiter_if;
    logic [31:0] c0_addr;
    logic [31:0] c1_addr;
    logic [3:0]  c0_rmask;
    logic [3:0]  c1_rmask;
    logic [3:0]  c0_wmask;
    logic [3:0]  c1_wmask;
    logic [31:0] c0_wdata;
    logic [31:0] c1_wdata;
    logic        c0_lock;
    logic        c1_lock;
    logic [31:0] c0_rdata;
    logic [31:0] c1_rdata;
    logic        c0_resp;
    logic        c1_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        owner;

    modport master (
        output c0_addr, c1_addr, c0_rmask, c1_rmask,
        output c0_wmask, c1_wmask, c0_wdata, c1_wdata,
        output c0_lock, c1_lock, mem_rdata, mem_resp,
        input  c0_rdata, c1_rdata, c0_resp, c1_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata, owner
    );

    modport slave (
        input  c0_addr, c1_addr, c0_rmask, c1_rmask,
        input  c0_wmask, c1_wmask, c0_wdata, c1_wdata,
        input  c0_lock, c1_lock, mem_rdata, mem_resp,
        output c0_rdata, c1_rdata, c0_resp, c1_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter: round-robin grant, one outstanding access,
// AMO lock keeps the port with the owner across read and write.
module dmem_arbiter (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;

    state_t      state, state_n;
    logic        prio, prio_n;
    logic        owner_q, owner_n;
    logic        load;
    logic        grant;
    logic [31:0] l_addr, l_wdata;
    logic [3:0]  l_rmask, l_wmask;

    logic act0, act1, own_act, own_lock;
    logic busy, done;

    assign act0     = |(bus.c0_rmask | bus.c0_wmask);
    assign act1     = |(bus.c1_rmask | bus.c1_wmask);
    assign own_act  = owner_q ? act1 : act0;
    assign own_lock = owner_q ? bus.c1_lock : bus.c0_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            state   <= state_n;
            prio    <= prio_n;
            owner_q <= owner_n;
        end
    end

    always_comb begin
        state_n = state;
        prio_n  = prio;
        owner_n = owner_q;
        load    = 1'b0;
        grant   = owner_q;
        unique case (state)
            IDLE: begin
                if (act0 | act1) begin
                    grant   = (act0 & act1) ? prio : act1;
                    load    = 1'b1;
                    owner_n = grant;
                    prio_n  = ~grant;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (bus.mem_resp)
                    state_n = own_lock ? LOCKED : IDLE;
            end
            LOCKED: begin
                // Re-grant to the lock holder leaves the round-robin pointer alone
                if (own_act) begin
                    load    = 1'b1;
                    state_n = BUSY;
                end else if (!own_lock) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_addr  <= '0;
            l_rmask <= '0;
            l_wmask <= '0;
            l_wdata <= '0;
        end else if (load) begin
            l_addr  <= grant ? bus.c1_addr  : bus.c0_addr;
            l_rmask <= grant ? bus.c1_rmask : bus.c0_rmask;
            l_wmask <= grant ? bus.c1_wmask : bus.c0_wmask;
            l_wdata <= grant ? bus.c1_wdata : bus.c0_wdata;
        end
    end

    assign busy = (state == BUSY);
    assign done = busy & bus.mem_resp;

    assign bus.mem_addr  = busy ? l_addr  : '0;
    assign bus.mem_rmask = busy ? l_rmask : '0;
    assign bus.mem_wmask = busy ? l_wmask : '0;
    assign bus.mem_wdata = busy ? l_wdata : '0;

    assign bus.c0_resp  = done & ~owner_q;
    assign bus.c1_resp  = done & owner_q;
    assign bus.c0_rdata = bus.c0_resp ? bus.mem_rdata : '0;
    assign bus.c1_rdata = bus.c1_resp ? bus.mem_rdata : '0;
    assign bus.owner    = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random stimulus for dmem_arbiter against a transaction-level
// model of who holds the memory port.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();
    dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  rm [2];
    logic [3:0]  wm [2];
    logic        lk [2];
    logic        mresp;
    logic [31:0] mdata;

    int total = 0;
    int fails = 0;

    // model: an access in flight, a lock held, who holds the port, who's next
    bit          m_busy, m_lock;
    int          m_own, m_rr;
    logic [31:0] q_addr, q_wdata;
    logic [3:0]  q_rm, q_wm;
    logic        got_resp [2];
    logic [31:0] got_rdata [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit act(input int i);
        return (rm[i] | wm[i]) != 4'd0;
    endfunction

    task automatic take(input int g);
        q_addr  = a[g];
        q_rm    = rm[g];
        q_wm    = wm[g];
        q_wdata = d[g];
        m_own   = g;
        m_busy  = 1'b1;
    endtask

    task automatic step(input bit r, input bit en = 1'b1);
        logic        er;
        logic        ob;
        logic [31:0] od;
        rst = r;
        bus.mem_resp = mresp;  bus.mem_rdata = mdata;
        bus.c0_addr = a[0];    bus.c1_addr = a[1];
        bus.c0_rmask = rm[0];  bus.c1_rmask = rm[1];
        bus.c0_wmask = wm[0];  bus.c1_wmask = wm[1];
        bus.c0_wdata = d[0];   bus.c1_wdata = d[1];
        bus.c0_lock = lk[0];   bus.c1_lock = lk[1];
        #4;
        if (en) begin
            chk("mem_addr",  bus.mem_addr,  m_busy ? q_addr : 32'd0);
            chk("mem_rmask", {28'd0, bus.mem_rmask}, {28'd0, m_busy ? q_rm : 4'd0});
            chk("mem_wmask", {28'd0, bus.mem_wmask}, {28'd0, m_busy ? q_wm : 4'd0});
            chk("mem_wdata", bus.mem_wdata, m_busy ? q_wdata : 32'd0);
            for (int i = 0; i < 2; i++) begin
                er = m_busy && mresp && (m_own == i);
                ob = (i == 1) ? bus.c1_resp : bus.c0_resp;
                od = (i == 1) ? bus.c1_rdata : bus.c0_rdata;
                chk(i == 1 ? "c1_resp" : "c0_resp", {31'd0, ob}, {31'd0, er});
                chk(i == 1 ? "c1_rdata" : "c0_rdata", od, er ? mdata : 32'd0);
            end
            chk("owner", {31'd0, bus.owner}, m_own);
        end
        got_resp[0] = bus.c0_resp;   got_resp[1] = bus.c1_resp;
        got_rdata[0] = bus.c0_rdata; got_rdata[1] = bus.c1_rdata;
        if (r) begin
            m_busy = 1'b0; m_lock = 1'b0; m_own = 0; m_rr = 0;
            q_addr = '0; q_rm = '0; q_wm = '0; q_wdata = '0;
        end else if (m_busy) begin
            if (mresp) begin
                m_busy = 1'b0;
                m_lock = lk[m_own];
            end
        end else if (m_lock) begin
            if (act(m_own)) begin
                take(m_own);
                m_lock = 1'b0;
            end else if (!lk[m_own]) begin
                m_lock = 1'b0;
            end
        end else if (act(0) || act(1)) begin
            int g;
            g = (act(0) && act(1)) ? m_rr : (act(1) ? 1 : 0);
            take(g);
            m_rr = 1 - g;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            a[i] = '0; d[i] = '0; rm[i] = '0; wm[i] = '0; lk[i] = 1'b0;
        end
        mresp = 1'b0;
        mdata = '0;
        m_busy = 1'b0; m_lock = 1'b0; m_own = 0; m_rr = 0;
        q_addr = '0; q_rm = '0; q_wm = '0; q_wdata = '0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0);
        step(1'b1);

        // single read
        a[0] = 32'h100; rm[0] = 4'hF;
        step(1'b0);
        chk("rd_addr_lat", bus.mem_addr, 32'h100);
        step(1'b0);
        step(1'b0);
        mresp = 1'b1; mdata = 32'hDEADBEEF;
        step(1'b0);
        chk("rd_resp0", {31'd0, got_resp[0]}, 32'd1);
        chk("rd_data0", got_rdata[0], 32'hDEADBEEF);
        chk("rd_resp1", {31'd0, got_resp[1]}, 32'd0);
        rm[0] = 4'h0; mresp = 1'b0;
        step(1'b0);

        // contention with alternating priority
        step(1'b1);
        a[0] = 32'h10; rm[0] = 4'hF;
        a[1] = 32'h20; rm[1] = 4'hF;
        step(1'b0);
        chk("cont_first", {31'd0, bus.owner}, 32'd0);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; rm[0] = 4'h0;
        step(1'b0);
        chk("cont_second_addr", bus.mem_addr, 32'h20);
        mresp = 1'b1;
        step(1'b0);
        chk("cont_resp1", {31'd0, got_resp[1]}, 32'd1);
        mresp = 1'b0; rm[0] = 4'hF;
        step(1'b0);
        chk("cont_third", {31'd0, bus.owner}, 32'd0);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; rm[0] = 4'h0; rm[1] = 4'h0;
        step(1'b0);

        // AMO: c1 holds the port across read and write while c0 waits
        a[1] = 32'h200; rm[1] = 4'hF; lk[1] = 1'b1;
        a[0] = 32'h300; rm[0] = 4'hF;
        step(1'b0);
        chk("amo_grant", {31'd0, bus.owner}, 32'd1);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; rm[1] = 4'h0; wm[1] = 4'hF; d[1] = 32'h1234;
        step(1'b0);
        step(1'b0);
        chk("amo_write", {28'd0, bus.mem_wmask}, 32'hF);
        chk("amo_owner", {31'd0, bus.owner}, 32'd1);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; wm[1] = 4'h0; lk[1] = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("amo_release", {31'd0, bus.owner}, 32'd0);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; rm[0] = 4'h0;
        step(1'b0);

        // partial store
        a[1] = 32'h40; wm[1] = 4'b0011; d[1] = 32'h0000ABCD;
        step(1'b0);
        chk("st_wdata", bus.mem_wdata, 32'h0000ABCD);
        mresp = 1'b1;
        step(1'b0);
        mresp = 1'b0; wm[1] = 4'h0;
        step(1'b0);
        chk("st_resp_width", {31'd0, got_resp[1]}, 32'd0);

        // reset mid-access, then a late response
        a[0] = 32'h80; rm[0] = 4'hF;
        step(1'b0);
        step(1'b1);
        rm[0] = 4'h0; mresp = 1'b1;
        step(1'b0);
        // stray response while idle
        step(1'b0);
        mresp = 1'b0;
        step(1'b0);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom % 4 == 0) begin
                    a[i]  = {$urandom_range(32'h3FFF_FFFF, 0), 2'b00};
                    rm[i] = ($urandom % 2 == 0) ? 4'($urandom) : 4'd0;
                    wm[i] = ($urandom % 3 == 0) ? 4'($urandom) : 4'd0;
                    d[i]  = $urandom;
                    lk[i] = ($urandom % 4 == 0);
                end
            end
            mresp = ($urandom % 3 == 0);
            mdata = $urandom;
            step($urandom % 64 == 0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have clk, input, 1: clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1: reset; synchronous, active-high; clock clk.
REQ-003 SHALL have c0_addr / c1_addr, input, 32 each: word-aligned request address from core 0 / core 1 mem stage.
REQ-004 SHALL have c0_rmask / c1_rmask, input, 4 each: byte read mask.
REQ-005 SHALL have c0_wmask / c1_wmask, input, 4 each: byte write mask.
REQ-006 SHALL have c0_wdata / c1_wdata, input, 32 each: store data.
REQ-007 SHALL have c0_lock / c1_lock, input, 1 each: AMO lock; requester keeps the port across AMO read and write.
REQ-008 SHALL have c0_rdata / c1_rdata, output, 32 each: read data returned to the core.
REQ-009 SHALL have c0_resp / c1_resp, output, 1 each: one-cycle completion strobe to the core.
REQ-010 SHALL have mem_addr, mem_rmask, mem_wmask, mem_wdata, output, 32/4/4/32: shared dmem port.
REQ-011 SHALL have mem_rdata, input, 32, and mem_resp, input, 1: shared dmem response.
REQ-012 SHALL have owner, output, 1: index of the current or last grantee, for debug/RVFI.

Function
REQ-013 SHALL define a requester as active when (rmask | wmask) != 0.
REQ-014 SHALL implement FSM states IDLE, BUSY, LOCKED.
REQ-015 SHALL, in IDLE with exactly one active requester, latch that requester's addr/masks/wdata into internal registers, set owner, and go to BUSY.
REQ-016 SHALL, in IDLE with both requesters active, grant the requester selected by the round-robin pointer prio; after each grant, prio becomes the non-granted index.
REQ-017 SHALL drive mem_* from the latched registers only while in BUSY; in IDLE and LOCKED, mem_addr, mask and wdata outputs SHALL be 0. Grant-to-port latency is 1 cycle: request seen at cycle N, mem_* valid at N+1.
REQ-018 SHALL hold mem_* constant in BUSY until mem_resp; the latched request SHALL NOT be re-sampled.
REQ-019 SHALL, on mem_resp in BUSY, assert c<owner>_resp in that same cycle (combinational) with c<owner>_rdata = mem_rdata; the non-owner's resp SHALL be 0 and its rdata SHALL be 0.
REQ-020 SHALL, on mem_resp in BUSY, go to LOCKED if c<owner>_lock = 1, else to IDLE.
REQ-021 SHALL, in LOCKED, ignore the non-owner entirely.
REQ-022 SHALL, in LOCKED, latch the owner's request and go to BUSY when the owner is active.
REQ-023 SHALL, in LOCKED, return to IDLE when c<owner>_lock = 0 and the owner is not active.
REQ-024 SHALL leave prio unchanged on LOCKED->BUSY re-grants.
REQ-025 SHALL ignore mem_resp in IDLE and LOCKED; no cX_resp SHALL be produced.
REQ-026 SHALL accept a request presented in the cycle immediately after a resp as a new request; an requester that is still active SHALL be re-served.
REQ-027 SHALL treat a request with both rmask and wmask nonzero as a single transaction, passed through unchanged.

Reset
REQ-028 SHALL, on rst, force state = IDLE, prio = 0, owner = 0, and clear the latched registers.
REQ-029 SHALL, after rst, drive all mem_* outputs, cX_resp and cX_rdata to 0.
REQ-030 SHALL apply rst mid-transaction with priority: the outstanding access is abandoned, and a late mem_resp after reset SHALL be ignored per REQ-025.

Verification
REQ-031 Single read: c0_addr=0x100, c0_rmask=F at cycle 0 -> mem_addr=0x100, mem_rmask=F at cycle 1; mem_resp with mem_rdata=0xDEADBEEF at cycle 3 -> c0_resp=1, c0_rdata=0xDEADBEEF, c1_resp=0.
REQ-032 Contention: both active at cycle 0 after reset -> core 0 served first; core 1 served next with mem_addr=c1_addr; then both active again -> core 0 granted (prio alternates).
REQ-033 AMO lock: c1 read 0x200 with c1_lock=1, c0 active throughout -> after resp the state is LOCKED; c1 write 0x200, wmask=F is served before any c0 access; c1_lock drops -> c0 is granted.
REQ-034 Store: c1_wmask=4'b0011, c1_wdata=0x0000ABCD, c1_addr=0x40 -> mem outputs match exactly; c1_resp is one cycle wide.
REQ-035 Reset mid-BUSY: rst while mem_rmask=F -> next cycle all mem_* = 0; a mem_resp one cycle later produces no cX_resp.
REQ-036 Stray resp: mem_resp=1 in IDLE -> c0_resp = c1_resp = 0 and state unchanged.
